// File: rtl/axis_seq_tagger_if.sv
// AXI-Stream bundle around the sequence tagger: the upstream s_* beat and the tagged m_* beat.
// slave is the tagger's view of the bundle; master is the view of the source/sink around it.
interface axis_seq_tagger_if #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_tdata;
  logic                  s_tvalid;
  logic                  s_tready;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic [USER_WIDTH-1:0] m_tuser;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;

  modport slave (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tuser, m_tlast, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tlast, m_tvalid
  );
endinterface

// File: rtl/axis_seq_tagger.sv
// Two-entry AXI-Stream register slice that tags each accepted beat with a wrapping
// sequence number on m_tuser and marks every FRAME_LEN-th beat with m_tlast.
//
// state | meaning
// EMPTY | nothing held, m_tvalid low, s_tready high
// FULL  | main register holds a beat, skid empty, s_tready high
// SKID  | main and skid both hold beats, s_tready low
module axis_seq_tagger #(
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  axis_seq_tagger_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  localparam int POS_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'((FRAME_LEN > 0) ? FRAME_LEN - 1 : 0);

  state_t                state;
  state_t                state_nxt;
  logic [USER_WIDTH-1:0] seq;
  logic [POS_W-1:0]      pos;
  logic                  s_tready_q;
  logic                  m_tvalid_q;

  logic [DATA_WIDTH-1:0] main_data;
  logic [USER_WIDTH-1:0] main_user;
  logic                  main_last;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [USER_WIDTH-1:0] skid_user;
  logic                  skid_last;

  logic                  in_hs;
  logic                  out_hs;
  logic [USER_WIDTH-1:0] tag;
  logic [POS_W-1:0]      p;
  logic [POS_W-1:0]      pos_nxt;
  logic                  beat_last;
  logic                  load_main;
  logic                  load_skid;
  logic                  pop_skid;

  assign in_hs  = bus.s_tvalid && s_tready_q;
  assign out_hs = m_tvalid_q && bus.m_tready;

  // clear applies to the beat accepted in the same cycle, so it restarts at tag 0 / pos 0
  assign tag       = clear ? '0 : seq;
  assign p         = clear ? '0 : pos;
  assign beat_last = (FRAME_LEN != 0) && (p == LAST_POS);
  assign pos_nxt   = (p == LAST_POS) ? '0 : p + POS_W'(1);

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_hs) begin
          state_nxt = FULL;
          load_main = 1'b1;
        end
      end
      FULL: begin
        if (in_hs && out_hs) begin
          load_main = 1'b1;
        end else if (in_hs) begin
          state_nxt = SKID;
          load_skid = 1'b1;
        end else if (out_hs) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (out_hs) begin
          state_nxt = FULL;
          pop_skid  = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
      seq        <= '0;
      pos        <= '0;
      main_data  <= '0;
      main_user  <= '0;
      main_last  <= 1'b0;
      skid_data  <= '0;
      skid_user  <= '0;
      skid_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      s_tready_q <= (state_nxt != SKID);
      m_tvalid_q <= (state_nxt != EMPTY);

      if (in_hs) begin
        seq <= tag + USER_WIDTH'(1);
        pos <= pos_nxt;
      end else if (clear) begin
        seq <= '0;
        pos <= '0;
      end

      if (load_main) begin
        main_data <= bus.s_tdata;
        main_user <= tag;
        main_last <= beat_last;
      end else if (pop_skid) begin
        main_data <= skid_data;
        main_user <= skid_user;
        main_last <= skid_last;
      end

      if (load_skid) begin
        skid_data <= bus.s_tdata;
        skid_user <= tag;
        skid_last <= beat_last;
      end
    end
  end

  assign bus.s_tready = s_tready_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tdata  = main_data;
  assign bus.m_tuser  = main_user;
  assign bus.m_tlast  = main_last;

endmodule

// File: tb/tb_axis_seq_tagger.sv
// Directed vector table plus hand-written reset/random sequences for axis_seq_tagger.
module tb_axis_seq_tagger;

  logic clock = 1'b0;
  logic reset;
  logic clear;

  always #5 clock = ~clock;

  axis_seq_tagger_if #(.DATA_WIDTH(8), .USER_WIDTH(4)) bus  ();
  axis_seq_tagger_if #(.DATA_WIDTH(8), .USER_WIDTH(8)) bus1 ();
  axis_seq_tagger_if #(.DATA_WIDTH(8), .USER_WIDTH(8)) bus0 ();

  // Framing-length corner instances share the main stimulus
  assign bus1.s_tdata  = bus.s_tdata;
  assign bus1.s_tvalid = bus.s_tvalid;
  assign bus1.m_tready = bus.m_tready;
  assign bus0.s_tdata  = bus.s_tdata;
  assign bus0.s_tvalid = bus.s_tvalid;
  assign bus0.m_tready = bus.m_tready;

  axis_seq_tagger #(.DATA_WIDTH(8), .USER_WIDTH(4), .FRAME_LEN(4)) dut (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus));
  axis_seq_tagger #(.DATA_WIDTH(8), .USER_WIDTH(8), .FRAME_LEN(1)) dut_f1 (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus1));
  axis_seq_tagger #(.DATA_WIDTH(8), .USER_WIDTH(8), .FRAME_LEN(0)) dut_f0 (
    .clock(clock), .reset(reset), .clear(clear), .bus(bus0));

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       clr;
    logic       e_srdy;
    logic       e_mval;
    logic [7:0] e_data;
    logic [3:0] e_user;
    logic       e_last;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] u;
    logic       l;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic void add_v(input logic sv, input logic [7:0] sd, input logic mr,
                                input logic clr, input logic e_srdy, input logic e_mval,
                                input logic [7:0] e_data, input logic [3:0] e_user,
                                input logic e_last);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mr = mr; v.clr = clr;
    v.e_srdy = e_srdy; v.e_mval = e_mval; v.e_data = e_data; v.e_user = e_user;
    v.e_last = e_last;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    n_vec++;
    if (v.e_mval)
      ok = (bus.s_tready === v.e_srdy) && (bus.m_tvalid === 1'b1) &&
           (bus.m_tdata === v.e_data) && (bus.m_tuser === v.e_user) &&
           (bus.m_tlast === v.e_last) && (bus1.m_tlast === 1'b1) && (bus0.m_tlast === 1'b0);
    else
      ok = (bus.s_tready === v.e_srdy) && (bus.m_tvalid === 1'b0);
    if (!ok) begin
      n_err++;
      $display("FAIL vec %0d: got rdy=%b val=%b data=%h user=%h last=%b f1_last=%b f0_last=%b; want rdy=%b val=%b data=%h user=%h last=%b f1_last=1 f0_last=0 (data fields only when valid)",
               idx, bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast,
               bus1.m_tlast, bus0.m_tlast, v.e_srdy, v.e_mval, v.e_data, v.e_user, v.e_last);
    end
  endtask

  initial begin
    logic [3:0] m_seq;
    logic [1:0] m_pos;
    int         n_out;
    beat_t      e;

    reset = 1'b1;
    clear = 1'b0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = 8'h00;
    bus.m_tready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state", 32'({bus.s_tready, bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast}), 32'h0);

    // sv  data   mr  clr  rdy val data   user last
    add_v(1, 8'h10, 1, 0,  1, 0, 8'h00, 4'h0, 0);
    add_v(1, 8'h10, 1, 0,  1, 1, 8'h10, 4'h0, 0);
    add_v(1, 8'h11, 1, 0,  1, 1, 8'h11, 4'h1, 0);
    add_v(1, 8'h12, 1, 0,  1, 1, 8'h12, 4'h2, 0);
    add_v(1, 8'h13, 1, 0,  1, 1, 8'h13, 4'h3, 1);
    add_v(1, 8'h14, 1, 0,  1, 1, 8'h14, 4'h4, 0);
    add_v(1, 8'h15, 1, 0,  1, 1, 8'h15, 4'h5, 0);
    add_v(1, 8'h16, 1, 0,  1, 1, 8'h16, 4'h6, 0);
    add_v(1, 8'h17, 1, 0,  1, 1, 8'h17, 4'h7, 1);
    add_v(1, 8'h18, 1, 0,  1, 1, 8'h18, 4'h8, 0);
    // downstream stalls three cycles: second beat lands in skid, ready drops
    add_v(1, 8'h19, 0, 0,  0, 1, 8'h18, 4'h8, 0);
    add_v(1, 8'h1A, 0, 0,  0, 1, 8'h18, 4'h8, 0);
    add_v(1, 8'h1A, 0, 0,  0, 1, 8'h18, 4'h8, 0);
    add_v(1, 8'h1A, 1, 0,  1, 1, 8'h19, 4'h9, 0);
    add_v(1, 8'h1A, 1, 0,  1, 1, 8'h1A, 4'hA, 0);
    add_v(1, 8'h1B, 1, 0,  1, 1, 8'h1B, 4'hB, 1);
    add_v(1, 8'h1C, 1, 0,  1, 1, 8'h1C, 4'hC, 0);
    add_v(1, 8'h1D, 0, 0,  0, 1, 8'h1C, 4'hC, 0);
    add_v(0, 8'h1E, 1, 0,  1, 1, 8'h1D, 4'hD, 0);
    // clear with acceptance: held beat keeps tag D, new beat restarts at 0
    add_v(1, 8'h1E, 0, 1,  0, 1, 8'h1D, 4'hD, 0);
    add_v(1, 8'h1F, 1, 0,  1, 1, 8'h1E, 4'h0, 0);
    add_v(1, 8'h1F, 1, 0,  1, 1, 8'h1F, 4'h1, 0);
    add_v(1, 8'h20, 1, 0,  1, 1, 8'h20, 4'h2, 0);
    add_v(1, 8'h21, 1, 0,  1, 1, 8'h21, 4'h3, 1);
    // clear without acceptance, slice drains
    add_v(0, 8'h22, 1, 1,  1, 0, 8'h00, 4'h0, 0);
    add_v(1, 8'h22, 1, 0,  1, 1, 8'h22, 4'h0, 0);
    for (int i = 1; i < 20; i++)
      add_v(1, 8'h22 + 8'(i), 1, 0, 1, 1, 8'h22 + 8'(i), 4'(i % 16), (i % 4) == 3);

    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h10;
    bus.m_tready = 1'b1;
    reset = 1'b0;
    foreach (vecs[i]) begin
      bus.s_tvalid = vecs[i].sv;
      bus.s_tdata  = vecs[i].sd;
      bus.m_tready = vecs[i].mr;
      clear        = vecs[i].clr;
      @(posedge clock);
      #1;
      check_vec(i, vecs[i]);
    end

    // Reset while SKID holds a beat
    clear = 1'b0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 8'h50;
    bus.m_tready = 1'b0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    chk("skid_ready_low", 32'(bus.s_tready), 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_mvalid", 32'(bus.m_tvalid), 32'h0);
    chk("async_rst_sready", 32'(bus.s_tready), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.s_tdata  = 8'h40;
    bus.m_tready = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_release_ready", 32'({bus.s_tready, bus.m_tvalid}), 32'h2);
    @(posedge clock);
    #1;
    chk("first_after_reset", 32'({bus.m_tvalid, bus.m_tdata, bus.m_tuser, bus.m_tlast}),
        32'({1'b1, 8'h40, 4'h0, 1'b0}));

    // Random handshakes against an independent scoreboard
    reset = 1'b1;
    bus.s_tvalid = 1'b0;
    bus.m_tready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    m_seq = 4'h0;
    m_pos = 2'd0;
    n_out = 0;
    for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
      bus.s_tvalid = 1'($urandom_range(0, 1));
      bus.s_tdata  = 8'($urandom_range(0, 255));
      bus.m_tready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (bus.m_tvalid && bus.m_tready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rand_extra_beat: got data=%h user=%h with no beat outstanding",
                   bus.m_tdata, bus.m_tuser);
        end else begin
          e = sb.pop_front();
          n_vec++;
          if ({bus.m_tdata, bus.m_tuser, bus.m_tlast} !== e) begin
            n_err++;
            $display("FAIL rand_beat %0d: got data=%h user=%h last=%b want data=%h user=%h last=%b",
                     n_out, bus.m_tdata, bus.m_tuser, bus.m_tlast, e.d, e.u, e.l);
          end
        end
      end
      if (bus.s_tvalid && bus.s_tready) begin
        sb.push_back({bus.s_tdata, m_seq, m_pos == 2'd3});
        m_seq = m_seq + 4'h1;
        m_pos = m_pos + 2'd1;
      end
      @(posedge clock);
      #1;
    end
    if (n_out < 10000) begin
      n_vec++;
      n_err++;
      $display("FAIL rand_timeout: got %0d beats out, want 10000", n_out);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
